split_bus_arbiter: RTL and testbench

//   Shares one split-transaction target port (req/ack + later resp) among NUM_HOSTS hosts.

---
 rtl/split_bus_arbiter_pkg.sv | 18 +
 rtl/split_bus_arbiter_if.sv | 19 +
 rtl/split_bus_arbiter_fifo.sv | 49 ++++
 rtl/split_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_split_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and constants for the split-transaction bus arbiter.
// Includes the bus widths, the arbiter state encoding and the host-index width helper.
package split_bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Host index width; a single-bit index is kept even for two hosts.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Split-transaction bus bundle with N request lanes sharing one read-data return.
// The master side issues requests; the slave side accepts them and returns responses.
interface split_bus_if #(
    parameter int N = 1
);
    import split_bus_pkg::*;

    logic [N-1:0]            req;
    logic [N-1:0]            ack;
    logic [N-1:0]            we;
    logic [BUS_DATA_W*N-1:0] addr;
    logic [BUS_DATA_W*N-1:0] wdata;
    logic [BUS_BE_W*N-1:0]   be;
    logic [N-1:0]            resp;
    logic [BUS_DATA_W-1:0]   rdata;

    modport master (output req, we, addr, wdata, be, input ack, resp, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/split_bus_arbiter_fifo.sv
// Synchronous FIFO of 2**W entries, B bits wide, with show-ahead read data.
// A write is accepted while full when a read happens in the same cycle.
module split_bus_arbiter_fifo #(
    parameter int B = 1,
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);
    localparam int DEPTH = 1 << W;

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] wr_ptr, rd_ptr;
    logic [W:0]   count;
    logic         do_rd, do_wr;

    assign empty  = (count == '0);
    assign full   = (count == (W+1)'(DEPTH));
    assign do_rd  = rd & ~empty;
    assign do_wr  = wr & (~full | do_rd);
    assign r_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need defined values.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= w_data;
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/split_bus_arbiter.sv
// Round-robin arbiter sharing one split-transaction target among NUM_HOSTS hosts.
// Grants lock until accepted; read responses return in order via a host-ID FIFO.
module split_bus_arbiter
    import split_bus_pkg::*;
#(
    parameter int NUM_HOSTS      = 2,
    parameter int ID_W           = id_width(NUM_HOSTS),
    parameter int ORDER_FIFO_POW = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    split_bus_if.slave  hosts,
    split_bus_if.master target,
    output logic       resp_err
);
    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
    logic [ID_W-1:0]      win_id, sel_id, head_id;
    logic                 win_valid, sel_valid, accept, push, pop;
    logic                 fifo_full, fifo_empty, resp_err_q, resp_err_d;
    logic [NUM_HOSTS-1:0] eligible;
    int                   idx;

    // Reads need a free ID slot to be issued; writes never do.
    assign eligible = hosts.req & (hosts.we | {NUM_HOSTS{~fifo_full}});

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_HOSTS) idx = idx - NUM_HOSTS;
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        resp_err_d = resp_err_q;
        sel_valid  = 1'b0;
        sel_id     = win_id;
        case (state_q)
            ST_IDLE: begin
                sel_valid = win_valid;
                sel_id    = win_id;
            end
            ST_LOCKED: begin
                sel_valid = hosts.req[lock_id_q];
                sel_id    = lock_id_q;
            end
            default: ;
        endcase
        accept = sel_valid & target.ack[0];
        if (accept) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (sel_id == ID_W'(NUM_HOSTS - 1)) ? '0 : sel_id + ID_W'(1);
        end else if (sel_valid) begin
            state_d   = ST_LOCKED;
            lock_id_d = sel_id;
        end else begin
            state_d = ST_IDLE;
        end
        if (target.resp[0] && fifo_empty) resp_err_d = 1'b1;
    end

    assign push = accept & ~hosts.we[sel_id];
    assign pop  = target.resp[0] & ~fifo_empty;

    // Request mux and response demux; everything is held at zero during reset.
    always_comb begin
        target.req   = '0;
        target.we    = '0;
        target.addr  = '0;
        target.wdata = '0;
        target.be    = '0;
        hosts.ack    = '0;
        hosts.resp   = '0;
        hosts.rdata  = '0;
        if (rst_ni) begin
            if (sel_valid) begin
                target.req[0]     = 1'b1;
                target.we[0]      = hosts.we[sel_id];
                target.addr       = hosts.addr[BUS_DATA_W*sel_id +: BUS_DATA_W];
                target.wdata      = hosts.wdata[BUS_DATA_W*sel_id +: BUS_DATA_W];
                target.be         = hosts.be[BUS_BE_W*sel_id +: BUS_BE_W];
                hosts.ack[sel_id] = target.ack[0];
            end
            if (pop) begin
                hosts.resp[head_id] = 1'b1;
                hosts.rdata         = target.rdata;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;

    split_bus_arbiter_fifo #(
        .B(ID_W),
        .W(ORDER_FIFO_POW)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .reset  (~rst_ni),
        .wr     (push),
        .rd     (pop),
        .w_data (sel_id),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .r_data (head_id)
    );
endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the arbitration and ordering rules.
module tb_split_bus_arbiter;
    localparam int N  = 2;
    localparam int FD = 16;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic resp_err;
    always #5 clk_i = ~clk_i;

    split_bus_if #(.N(N)) hosts ();
    split_bus_if #(.N(1)) tgt ();

    split_bus_arbiter #(
        .NUM_HOSTS(N),
        .ID_W(1),
        .ORDER_FIFO_POW(4)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .hosts   (hosts),
        .target  (tgt),
        .resp_err(resp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: round-robin pointer, lock owner and the queue of outstanding read IDs.
    int m_rr;
    bit m_locked;
    int m_lock;
    int id_q[$];
    bit m_err;
    int last_acc;

    logic [N-1:0] obs_ack, obs_resp;
    logic [31:0]  obs_rdata, obs_addr;
    logic         obs_req, obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        if (m_locked) return hosts.req[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (hosts.req[i] && (hosts.we[i] || id_q.size() < FD)) return i;
        end
        return -1;
    endfunction

    task automatic idle();
        hosts.req   = '0;
        hosts.we    = '0;
        hosts.addr  = '0;
        hosts.wdata = '0;
        hosts.be    = '0;
        tgt.ack     = '0;
        tgt.resp    = '0;
        tgt.rdata   = '0;
    endtask

    task automatic set_host(input int i, input bit we, input logic [31:0] addr);
        hosts.req[i]           = 1'b1;
        hosts.we[i]            = we;
        hosts.addr[32*i +: 32] = addr;
        hosts.wdata[32*i +: 32] = ~addr;
        hosts.be[4*i +: 4]     = addr[3:0];
    endtask

    // One cycle: inputs already applied; check at the falling edge, then advance the model.
    task automatic step();
        int s;
        logic [N-1:0] e_ack, e_resp;
        logic [31:0]  e_rdata, e_addr, e_wdata;
        logic [3:0]   e_be;
        logic         e_we;
        #4;
        s = pick();
        e_ack = '0; e_resp = '0; e_rdata = '0;
        e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
        if (s >= 0) begin
            e_addr  = hosts.addr[32*s +: 32];
            e_wdata = hosts.wdata[32*s +: 32];
            e_be    = hosts.be[4*s +: 4];
            e_we    = hosts.we[s];
            if (tgt.ack[0]) e_ack[s] = 1'b1;
        end
        if (tgt.resp[0] && id_q.size() > 0) begin
            e_resp[id_q[0]] = 1'b1;
            e_rdata         = tgt.rdata;
        end
        obs_ack = hosts.ack; obs_resp = hosts.resp; obs_rdata = hosts.rdata;
        obs_req = tgt.req[0]; obs_addr = tgt.addr; obs_err = resp_err;
        check("target_req",   tgt.req[0], s >= 0);
        check("target_we",    tgt.we[0], e_we);
        check("target_addr",  tgt.addr, e_addr);
        check("target_wdata", tgt.wdata, e_wdata);
        check("target_be",    tgt.be, e_be);
        check("host_ack",     hosts.ack, e_ack);
        check("host_resp",    hosts.resp, e_resp);
        check("host_rdata",   hosts.rdata, e_rdata);
        check("resp_err",     resp_err, m_err);
        last_acc = (s >= 0 && tgt.ack[0]) ? s : -1;
        @(posedge clk_i);
        if (tgt.resp[0]) begin
            if (id_q.size() > 0) void'(id_q.pop_front());
            else m_err = 1'b1;
        end
        if (last_acc >= 0) begin
            if (!hosts.we[s]) id_q.push_back(s);
            m_rr     = (s + 1) % N;
            m_locked = 1'b0;
        end else if (s >= 0) begin
            m_locked = 1'b1;
            m_lock   = s;
        end else begin
            m_locked = 1'b0;
        end
        #1;
    endtask

    // Called just after a rising edge; pulses reset for one cycle with busy inputs applied.
    task automatic do_reset();
        rst_ni     = 1'b0;
        hosts.req  = '1;
        tgt.ack    = '1;
        tgt.resp   = '1;
        tgt.rdata  = 32'hCAFE_F00D;
        #3;
        check("rst_target_req",  tgt.req, '0);
        check("rst_target_addr", tgt.addr, '0);
        check("rst_target_we",   {tgt.we, tgt.be, tgt.wdata}, '0);
        check("rst_host_ack",    hosts.ack, '0);
        check("rst_host_resp",   hosts.resp, '0);
        check("rst_host_rdata",  hosts.rdata, '0);
        check("rst_resp_err",    resp_err, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        m_rr     = 0;
        m_locked = 1'b0;
        m_lock   = 0;
        id_q.delete();
        m_err    = 1'b0;
        idle();
    endtask

    bit busy[N];

    initial begin
        rst_ni = 1'b0;
        idle();
        @(posedge clk_i);
        #1;
        do_reset();

        // Idle host0 read accepted immediately, response three cycles later.
        set_host(0, 1'b0, 32'h0000_0100);
        tgt.ack = 1'b1;
        step();
        check("t1_ack", obs_ack, 2'b01);
        idle();
        step();
        step();
        tgt.resp  = 1'b1;
        tgt.rdata = 32'hDEAD_BEEF;
        step();
        check("t1_resp", obs_resp, 2'b01);
        check("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("t1_err", obs_err, 1'b0);

        // Both hosts writing continuously with the target always ready: grants alternate.
        idle();
        set_host(0, 1'b1, 32'h0000_1000);
        set_host(1, 1'b1, 32'h0000_2000);
        tgt.ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t2_alt", obs_ack, (k % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Host1 locked while the target stalls; host0 must wait for host1's accept.
        idle();
        set_host(1, 1'b1, 32'h0000_2004);
        step();
        check("t3_lock_addr", obs_addr, 32'h0000_2004);
        step();
        set_host(0, 1'b1, 32'h0000_1004);
        for (int k = 0; k < 2; k++) begin
            step();
            check("t3_hold_addr", obs_addr, 32'h0000_2004);
        end
        tgt.ack = 1'b1;
        step();
        check("t3_h1_ack", obs_ack, 2'b10);
        hosts.req[1] = 1'b0;
        step();
        check("t3_h0_ack", obs_ack, 2'b01);

        // Fill the ID FIFO with 16 host0 reads, then show reads blocked and writes passing.
        idle();
        set_host(0, 1'b0, 32'h0000_3000);
        tgt.ack = 1'b1;
        for (int k = 0; k < FD; k++) step();
        hosts.req[0] = 1'b0;
        set_host(1, 1'b0, 32'h0000_4000);
        step();
        check("t4_read_held", obs_req, 1'b0);
        hosts.we[1] = 1'b1;
        step();
        check("t4_write_req", obs_req, 1'b1);
        check("t4_write_ack", obs_ack, 2'b10);
        hosts.we[1] = 1'b0;
        tgt.resp    = 1'b1;
        tgt.rdata   = 32'h1111_1111;
        step();
        check("t4_full_held", obs_req, 1'b0);
        check("t4_first_resp", obs_resp, 2'b01);
        tgt.resp = 1'b0;
        step();
        check("t4_read_issue", obs_ack, 2'b10);
        idle();
        tgt.resp = 1'b1;
        for (int k = 0; k < FD; k++) begin
            tgt.rdata = $urandom;
            step();
        end
        check("t4_last_resp", obs_resp, 2'b10);

        // Interleaved reads h0,h1,h0 with the third push coinciding with the first pop.
        idle();
        tgt.ack = 1'b1;
        set_host(0, 1'b0, 32'h0000_5000);
        step();
        hosts.req[0] = 1'b0;
        set_host(1, 1'b0, 32'h0000_6000);
        step();
        hosts.req[1] = 1'b0;
        set_host(0, 1'b0, 32'h0000_5004);
        tgt.resp  = 1'b1;
        tgt.rdata = 32'hA0A0_0001;
        step();
        check("t5_ack3", obs_ack, 2'b01);
        check("t5_resp1", obs_resp, 2'b01);
        idle();
        tgt.resp  = 1'b1;
        tgt.rdata = 32'hA0A0_0002;
        step();
        check("t5_resp2", obs_resp, 2'b10);
        tgt.rdata = 32'hA0A0_0003;
        step();
        check("t5_resp3", obs_resp, 2'b01);
        tgt.resp = 1'b0;
        step();
        check("t5_drained_err", obs_err, 1'b0);

        // Random traffic; requests stay stable until accepted.
        idle();
        for (int i = 0; i < N; i++) busy[i] = 1'b0;
        last_acc = -1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (busy[i] && last_acc == i) begin
                    busy[i]      = 1'b0;
                    hosts.req[i] = 1'b0;
                end
                if (!busy[i] && $urandom_range(2) != 0) begin
                    busy[i] = 1'b1;
                    set_host(i, 1'($urandom_range(2) == 0), $urandom);
                end
            end
            tgt.ack[0]  = 1'($urandom_range(1));
            tgt.resp[0] = (id_q.size() > 0) && ($urandom_range(2) == 0);
            tgt.rdata   = $urandom;
            step();
        end

        // Drain, leave two reads outstanding, reset, then a late response.
        idle();
        for (int k = 0; k < 20 && id_q.size() > 0; k++) begin
            tgt.resp  = 1'b1;
            tgt.rdata = $urandom;
            step();
        end
        idle();
        set_host(0, 1'b0, 32'h0000_7000);
        tgt.ack = 1'b1;
        step();
        step();
        do_reset();
        tgt.resp  = 1'b1;
        tgt.rdata = 32'h5555_AAAA;
        step();
        check("t6_no_resp", obs_resp, 2'b00);
        tgt.resp = 1'b0;
        step();
        check("t6_err", obs_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
